// File: rtl/alarm_pkg.sv
// Shared types and reset constants for the alarm sequencing logic.
package alarm_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RINGING = 2'd1,
      SNOOZE  = 2'd2
   } alarm_state_t;

   localparam logic [7:0] ALM_HH_RST = 8'h12;
   localparam logic [7:0] ALM_MM_RST = 8'h00;
   localparam logic [7:0] ALM_SS_RST = 8'h00;

   typedef struct packed {
      logic [7:0] hh;
      logic [7:0] mm;
      logic [7:0] ss;
      logic       pm;
   } bcd_time_t;

   function automatic bcd_time_t pack_time(input logic [7:0] hh, input logic [7:0] mm,
                                           input logic [7:0] ss, input logic pm);
      bcd_time_t t;
      t.hh = hh;
      t.mm = mm;
      t.ss = ss;
      t.pm = pm;
      return t;
   endfunction

endpackage

// File: rtl/sec_down_counter.sv
// Loadable down-counter stepped by an external tick; zero flag is combinational from the count.
// Load takes effect on the next clk and wins over tick; no backpressure.
module sec_down_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         tick,
   output logic [W-1:0] count,
   output logic         zero
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (tick) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/alarm_ring_controller.sv
// Alarm sequencer: compares BCD time to the stored alarm and runs ring/snooze/timeout.
// All outputs registered, one clk after the causing input; no backpressure.
import alarm_pkg::*;

module alarm_ring_controller #(
   parameter int SNOOZE_SEC       = 300,
   parameter int RING_TIMEOUT_SEC = 60,
   parameter int MAX_SNOOZE       = 3
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              sec_tick,
   input  logic [7:0]                        hh,
   input  logic [7:0]                        mm,
   input  logic [7:0]                        ss,
   input  logic                              pm,
   input  logic                              load_alarm,
   input  logic [7:0]                        hh_load,
   input  logic [7:0]                        mm_load,
   input  logic [7:0]                        ss_load,
   input  logic                              pm_load,
   input  logic                              alarm_toggle,
   input  logic                              alarm_stop,
   input  logic                              snooze,
   output logic                              alarm_on,
   output logic                              buzzer,
   output logic                              snoozing,
   output logic [$clog2(MAX_SNOOZE+1)-1:0]   snooze_left
);

   localparam int SN_W = $clog2(SNOOZE_SEC + 1);
   localparam int RT_W = $clog2(RING_TIMEOUT_SEC + 1);
   localparam int SL_W = $clog2(MAX_SNOOZE + 1);

   localparam logic [RT_W-1:0] RING_LAST = RT_W'(RING_TIMEOUT_SEC - 1);
   localparam logic [SL_W-1:0] SNZ_FULL  = SL_W'(MAX_SNOOZE);

   alarm_state_t    state, state_nxt;
   bcd_time_t       cur, alm;
   logic            match, match_q, trigger;
   logic            snooze_q, snz_edge;
   logic            cancel;
   logic [RT_W-1:0] ring_cnt, ring_cnt_nxt;
   logic            buzzer_nxt;
   logic [SL_W-1:0] snooze_left_nxt;
   logic            snz_load, snz_dec, snz_zero;
   logic [SN_W-1:0] snz_cnt;

   assign cur      = pack_time(hh, mm, ss, pm);
   assign match    = (cur == alm);
   assign trigger  = match & ~match_q & alarm_toggle;
   assign snz_edge = snooze & ~snooze_q;
   assign cancel   = load_alarm | ~alarm_toggle | alarm_stop;

   sec_down_counter #(.W(SN_W)) u_snz_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (snz_load),
      .load_val (SN_W'(SNOOZE_SEC)),
      .tick     (snz_dec),
      .count    (snz_cnt),
      .zero     (snz_zero)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      ring_cnt_nxt    = ring_cnt;
      buzzer_nxt      = buzzer;
      snooze_left_nxt = snooze_left;
      snz_load        = 1'b0;
      snz_dec         = 1'b0;
      case (state)
         IDLE: begin
            buzzer_nxt = 1'b0;
            if (trigger) begin
               state_nxt       = RINGING;
               ring_cnt_nxt    = '0;
               snooze_left_nxt = SNZ_FULL;
               buzzer_nxt      = 1'b1;
            end
         end
         RINGING: begin
            if (cancel) begin
               state_nxt  = IDLE;
               buzzer_nxt = 1'b0;
            end else if (snz_edge && snooze_left != '0) begin
               state_nxt       = SNOOZE;
               snz_load        = 1'b1;
               snooze_left_nxt = snooze_left - 1'b1;
               buzzer_nxt      = 1'b0;
            end else if (sec_tick) begin
               if (ring_cnt == RING_LAST) begin
                  state_nxt  = IDLE;
                  buzzer_nxt = 1'b0;
               end else begin
                  ring_cnt_nxt = ring_cnt + 1'b1;
                  buzzer_nxt   = ~buzzer;
               end
            end
         end
         SNOOZE: begin
            buzzer_nxt = 1'b0;
            if (cancel) begin
               state_nxt = IDLE;
            end else if (sec_tick) begin
               snz_dec = ~snz_zero;
               // expiry is decided on the tick that takes the timer 1 -> 0
               if (snz_cnt == SN_W'(1)) begin
                  state_nxt    = RINGING;
                  ring_cnt_nxt = '0;
                  buzzer_nxt   = 1'b1;
               end
            end
         end
         default: begin
            state_nxt  = IDLE;
            buzzer_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         alm         <= pack_time(ALM_HH_RST, ALM_MM_RST, ALM_SS_RST, 1'b0);
         match_q     <= 1'b0;
         snooze_q    <= 1'b0;
         ring_cnt    <= '0;
         alarm_on    <= 1'b0;
         buzzer      <= 1'b0;
         snoozing    <= 1'b0;
         snooze_left <= SNZ_FULL;
      end else begin
         if (load_alarm) begin
            alm <= pack_time(hh_load, mm_load, ss_load, pm_load);
         end
         match_q     <= match;
         snooze_q    <= snooze;
         ring_cnt    <= ring_cnt_nxt;
         alarm_on    <= (state_nxt == RINGING);
         buzzer      <= buzzer_nxt;
         snoozing    <= (state_nxt == SNOOZE);
         snooze_left <= snooze_left_nxt;
      end
   end

endmodule

// File: tb/tb_alarm_ring_controller.sv
// Scoreboard bench for alarm_ring_controller with SNOOZE_SEC=5, RING_TIMEOUT_SEC=4, MAX_SNOOZE=2.
module tb_alarm_ring_controller;

   logic       clk;
   logic       reset;
   logic       sec_tick;
   logic [7:0] hh, mm, ss;
   logic       pm;
   logic       load_alarm;
   logic [7:0] hh_load, mm_load, ss_load;
   logic       pm_load;
   logic       alarm_toggle;
   logic       alarm_stop;
   logic       snooze;
   logic       alarm_on;
   logic       buzzer;
   logic       snoozing;
   logic [1:0] snooze_left;

   int vec_cnt  = 0;
   int err_cnt  = 0;
   logic [4:0] exp_q[$];

   alarm_ring_controller #(
      .SNOOZE_SEC       (5),
      .RING_TIMEOUT_SEC (4),
      .MAX_SNOOZE       (2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .sec_tick     (sec_tick),
      .hh           (hh),
      .mm           (mm),
      .ss           (ss),
      .pm           (pm),
      .load_alarm   (load_alarm),
      .hh_load      (hh_load),
      .mm_load      (mm_load),
      .ss_load      (ss_load),
      .pm_load      (pm_load),
      .alarm_toggle (alarm_toggle),
      .alarm_stop   (alarm_stop),
      .snooze       (snooze),
      .alarm_on     (alarm_on),
      .buzzer       (buzzer),
      .snoozing     (snoozing),
      .snooze_left  (snooze_left)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // {alarm_on, buzzer, snoozing, snooze_left}
   function automatic logic [4:0] ex(input bit on, input bit bz, input bit sn, input int left);
      return {on, bz, sn, 2'(left)};
   endfunction

   task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input logic p);
      hh = h; mm = m; ss = s; pm = p;
   endtask

   task automatic load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input logic p);
      hh_load = h; mm_load = m; ss_load = s; pm_load = p;
      load_alarm = 1'b1;
   endtask

   task automatic step(input string tag, input bit tk, input logic [4:0] e);
      sec_tick = tk;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      sec_tick   = 1'b0;
      load_alarm = 1'b0;
      chk(tag, {27'd0, alarm_on, buzzer, snoozing, snooze_left}, {27'd0, exp_q.pop_front()});
   endtask

   // re-arm the edge detector by leaving and re-entering the 08:32:02 AM alarm second
   task automatic retrigger(input string tag, input int left_idle);
      set_time(8'h08, 8'h32, 8'h03, 1'b0);
      step({tag, "_away"}, 0, ex(0, 0, 0, left_idle));
      set_time(8'h08, 8'h32, 8'h02, 1'b0);
      step({tag, "_ring"}, 0, ex(1, 1, 0, 2));
   endtask

   initial begin
      reset        = 1'b1;
      sec_tick     = 1'b0;
      load_alarm   = 1'b0;
      alarm_toggle = 1'b1;
      alarm_stop   = 1'b0;
      snooze       = 1'b0;
      set_time(8'h01, 8'h00, 8'h00, 1'b0);
      hh_load = 8'h00; mm_load = 8'h00; ss_load = 8'h00; pm_load = 1'b0;

      #2 reset = 1'b0;
      #2 chk("reset_async", {27'd0, alarm_on, buzzer, snoozing, snooze_left}, {27'd0, ex(0, 0, 0, 2)});
      @(posedge clk); #1;
      chk("reset_hold", {27'd0, alarm_on, buzzer, snoozing, snooze_left}, {27'd0, ex(0, 0, 0, 2)});
      @(negedge clk);
      reset = 1'b1;

      // basic ring and timeout
      load(8'h08, 8'h32, 8'h02, 1'b0);
      set_time(8'h08, 8'h32, 8'h01, 1'b0);
      step("load_idle", 0, ex(0, 0, 0, 2));
      set_time(8'h08, 8'h32, 8'h02, 1'b0);
      step("match_ring", 0, ex(1, 1, 0, 2));
      step("tick1", 1, ex(1, 0, 0, 2));
      step("no_tick", 0, ex(1, 0, 0, 2));
      step("tick2", 1, ex(1, 1, 0, 2));
      step("tick3", 1, ex(1, 0, 0, 2));
      step("tick4_timeout", 1, ex(0, 0, 0, 2));
      step("held_match1", 0, ex(0, 0, 0, 2));
      step("held_match2", 1, ex(0, 0, 0, 2));

      // snooze cycle, exhaust snoozes
      retrigger("snz", 2);
      snooze = 1'b1;
      step("snooze1", 0, ex(0, 0, 1, 1));
      step("snz_held_tick", 1, ex(0, 0, 1, 1));
      snooze = 1'b0;
      for (int i = 0; i < 3; i++) step("snz1_wait", 1, ex(0, 0, 1, 1));
      step("snz1_expire", 1, ex(1, 1, 0, 1));
      snooze = 1'b1;
      step("snooze2", 0, ex(0, 0, 1, 0));
      snooze = 1'b0;
      step("snz2_idle", 0, ex(0, 0, 1, 0));
      for (int i = 0; i < 4; i++) step("snz2_wait", 1, ex(0, 0, 1, 0));
      step("snz2_expire", 1, ex(1, 1, 0, 0));
      snooze = 1'b1;
      step("snooze3_ignored", 0, ex(1, 1, 0, 0));
      snooze = 1'b0;
      step("after_snz3", 0, ex(1, 1, 0, 0));
      step("ring_tick", 1, ex(1, 0, 0, 0));
      alarm_stop = 1'b1;
      step("stop_ring", 0, ex(0, 0, 0, 0));
      alarm_stop = 1'b0;

      // stop during snooze
      retrigger("stop_snz", 0);
      snooze = 1'b1;
      step("snz_enter", 0, ex(0, 0, 1, 1));
      snooze = 1'b0;
      alarm_stop = 1'b1;
      step("stop_in_snz", 0, ex(0, 0, 0, 1));

      // stop held in idle does not block trigger; then it stops the ring
      set_time(8'h08, 8'h32, 8'h03, 1'b0);
      step("stop_idle_away", 0, ex(0, 0, 0, 1));
      set_time(8'h08, 8'h32, 8'h02, 1'b0);
      step("stop_idle_trig", 0, ex(1, 1, 0, 2));
      step("stop_held_ring", 0, ex(0, 0, 0, 2));
      alarm_stop = 1'b0;

      // disarmed at match
      set_time(8'h08, 8'h32, 8'h03, 1'b0);
      step("disarm_away", 0, ex(0, 0, 0, 2));
      alarm_toggle = 1'b0;
      set_time(8'h08, 8'h32, 8'h02, 1'b0);
      step("disarm_match", 0, ex(0, 0, 0, 2));
      alarm_toggle = 1'b1;
      step("rearm_same_sec", 0, ex(0, 0, 0, 2));

      // disarm while ringing
      retrigger("disarm_ring", 2);
      alarm_toggle = 1'b0;
      step("disarm_ringing", 0, ex(0, 0, 0, 2));
      alarm_toggle = 1'b1;

      // stop and snooze together
      retrigger("stop_snz_same", 2);
      alarm_stop = 1'b1;
      snooze     = 1'b1;
      step("stop_and_snooze", 0, ex(0, 0, 0, 2));
      alarm_stop = 1'b0;
      snooze     = 1'b0;

      // load while ringing cancels and captures the new alarm
      retrigger("load_ring", 2);
      load(8'h09, 8'h15, 8'h30, 1'b1);
      step("load_cancel", 0, ex(0, 0, 0, 2));
      retrigger_none: begin
         set_time(8'h08, 8'h32, 8'h03, 1'b0);
         step("old_alarm_away", 0, ex(0, 0, 0, 2));
         set_time(8'h08, 8'h32, 8'h02, 1'b0);
         step("old_alarm_gone", 0, ex(0, 0, 0, 2));
      end
      set_time(8'h09, 8'h15, 8'h30, 1'b1);
      step("new_alarm_rings", 0, ex(1, 1, 0, 2));
      alarm_stop = 1'b1;
      step("new_alarm_stop", 0, ex(0, 0, 0, 2));
      alarm_stop = 1'b0;

      // load equal to current time in idle rings on the following clk
      set_time(8'h10, 8'h00, 8'h00, 1'b0);
      step("move_time", 0, ex(0, 0, 0, 2));
      load(8'h10, 8'h00, 8'h00, 1'b0);
      step("load_now", 0, ex(0, 0, 0, 2));
      step("load_now_ring", 0, ex(1, 1, 0, 2));
      snooze = 1'b1;
      step("pre_rst_snz", 0, ex(0, 0, 1, 1));
      snooze = 1'b0;
      for (int i = 0; i < 4; i++) step("pre_rst_wait", 1, ex(0, 0, 1, 1));
      step("pre_rst_ring", 1, ex(1, 1, 0, 1));

      // async reset between edges mid-ring
      #2 reset = 1'b0;
      #1;
      chk("rst_alarm_on", {31'd0, alarm_on}, 32'd0);
      chk("rst_buzzer", {31'd0, buzzer}, 32'd0);
      chk("rst_snoozing", {31'd0, snoozing}, 32'd0);
      chk("rst_snooze_left", {30'd0, snooze_left}, 32'd2);
      set_time(8'h12, 8'h00, 8'h00, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      step("rst_alarm_reg_match", 0, ex(1, 1, 0, 2));
      alarm_stop = 1'b1;
      step("rst_stop", 0, ex(0, 0, 0, 2));
      alarm_stop = 1'b0;
      set_time(8'h10, 8'h00, 8'h00, 1'b0);
      step("old_load_cleared", 0, ex(0, 0, 0, 2));
      step("old_load_cleared2", 0, ex(0, 0, 0, 2));

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/alarm_ring_controller.md
Name: alarm_ring_controller

Overview:
- Sequences the alarm function of the alarm clock: holds the alarm time, detects when the running BCD time reaches it, and drives the ring, snooze, stop and timeout behaviour.
- Sits beside the time-keeping counter. Consumes its hh/mm/ss/pm outputs and a one-per-second tick; drives the alarm_on indicator and buzzer.

Parameters:
- SNOOZE_SEC, 300: snooze duration in seconds.
- RING_TIMEOUT_SEC, 60: seconds of unanswered ringing before auto-stop.
- MAX_SNOOZE, 3: snoozes allowed per alarm event.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- sec_tick  in  1  one-clk pulse per elapsed second
- hh, mm, ss  in  8 each  current time, packed BCD, 12-hour
- pm  in  1  current meridiem
- load_alarm  in  1  capture the *_load values into the alarm registers
- hh_load, mm_load, ss_load  in  8 each  alarm time, BCD
- pm_load  in  1  alarm meridiem
- alarm_toggle  in  1  level arm enable; 1 = armed
- alarm_stop  in  1  level; stops ringing or snooze
- snooze  in  1  snooze request, rising-edge detected internally
- alarm_on  out  1  high while state is RINGING
- buzzer  out  1  buzzer drive
- snoozing  out  1  high while state is SNOOZE
- snooze_left  out  $clog2(MAX_SNOOZE+1)  snoozes remaining

Behaviour:
- Reset (reset=0, async) puts the block in this state:
  - state = IDLE.
  - Alarm registers = 8'h12 : 8'h00 : 8'h00, AM.
  - match_q = 0, snooze_q = 0, timers = 0.
  - alarm_on = 0, buzzer = 0, snoozing = 0, snooze_left = MAX_SNOOZE.
- Outputs are registered.
- match = (hh, mm, ss, pm) equals the alarm registers. match_q is the previous-cycle match. Trigger = match & ~match_q & alarm_toggle. A trigger is only acted on in IDLE; it is ignored in RINGING and SNOOZE.
- States:
  - IDLE: on trigger, go to RINGING next clk, with ring_cnt = 0, snooze_left = MAX_SNOOZE, buzzer = 1.
  - RINGING:
    - On each sec_tick: ring_cnt++ and buzzer toggles.
    - Tick with ring_cnt == RING_TIMEOUT_SEC-1 goes to IDLE (timeout).
    - Snooze rising edge with snooze_left > 0 goes to SNOOZE: snz_cnt = SNOOZE_SEC, snooze_left--, buzzer = 0.
    - Snooze edge with snooze_left == 0 is ignored.
  - SNOOZE:
    - On each sec_tick, snz_cnt--.
    - Tick with snz_cnt == 1 goes to RINGING with ring_cnt = 0, buzzer = 1. snooze_left is not restored.
- Exit priority in RINGING/SNOOZE, highest first:
  1. load_alarm (cancel to IDLE)
  2. alarm_toggle = 0 (IDLE)
  3. alarm_stop (IDLE)
  4. snooze edge
  5. sec_tick timer events
- load_alarm in any state updates the alarm registers the same clk. match_q still tracks the old comparison, so a load equal to the current time triggers on the next clk if the block is in IDLE and armed.
- alarm_stop held in IDLE has no effect; a trigger still fires.
- buzzer = 0 in every state other than RINGING.
- Latency: trigger cycle N, alarm_on = 1 at N+1. Snooze edge at N, snoozing = 1 at N+1.
- Reset asserted mid-ring clears alarm_on/buzzer immediately (async) and reloads the alarm registers to their reset value.
- Timer widths: $clog2(SNOOZE_SEC+1) and $clog2(RING_TIMEOUT_SEC+1). No wrap is possible by construction.

Decomposition:
- Shared package alarm_pkg:
  - state enum {IDLE, RINGING, SNOOZE}
  - BCD reset constants ALM_HH_RST = 8'h12, ALM_MM_RST = 8'h00, ALM_SS_RST = 8'h00
  - bcd_time_t struct (hh, mm, ss, pm)
- One sub-module, sec_down_counter: loadable, tick-enabled down-counter with zero flag. Used for the snooze timer.
- The ring timer is an up-counter kept inline.

Test Plan:
All cases use SNOOZE_SEC=5, RING_TIMEOUT_SEC=4, MAX_SNOOZE=2.
- Basic ring: load alarm 08:32:02 AM, armed, time advances 08:32:01 -> 08:32:02 -> alarm_on = 1 one clk after the match, buzzer = 1 then toggling per tick, snooze_left = 2.
- Timeout: no input after trigger -> alarm_on falls on the 4th sec_tick, buzzer = 0, IDLE. Match held the same second does not retrigger.
- Snooze cycle: snooze pulse while ringing -> snoozing = 1, snooze_left = 1, buzzer = 0. After 5 ticks -> alarm_on = 1 again. Second snooze -> snooze_left = 0. Third snooze -> ignored, alarm keeps ringing.
- Stop/disarm: alarm_stop during SNOOZE -> IDLE next clk. alarm_toggle = 0 at the match time -> no ring. alarm_stop and snooze in the same clk -> IDLE.
- load_alarm while ringing -> IDLE next clk, new alarm value captured. Load equal to the current time while in IDLE and armed -> ring next clk.
- Async reset (reset = 0) mid-RINGING, between clk edges -> alarm_on/buzzer = 0 immediately, snooze_left = 2, alarm registers = 12:00:00 AM.
